// File: rtl/spi_pwm_pkg.sv
// Shared constants for the SPI-programmable PWM driver: register map,
// command byte layout and the reset period value.
package spi_pwm_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CMD_W      = 8;
  localparam int unsigned CMD_WR_BIT = 7;

  localparam logic [ADDR_W-1:0] ADDR_PERIOD = 7'h40;
  localparam logic [ADDR_W-1:0] ADDR_EN     = 7'h41;
  localparam logic [ADDR_W-1:0] ADDR_INV    = 7'h42;

  // Reset period TOP = 2^w - 2, so the default period is 2^w - 1 clocks.
  function automatic logic [15:0] reset_top(input int unsigned w);
    return 16'((32'd1 << w) - 32'd2);
  endfunction

endpackage

// File: rtl/spi_pwm_spi_slave.sv
// Mode-0 SPI register slave: synchronises the pins, decodes command/data
// frames, auto-increments the address and emits a one-clock write strobe.
module spi_pwm_spi_slave
  import spi_pwm_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  input  logic [PWM_W-1:0]  rd_data,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PWM_W-1:0]  wr_data
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned RX_W  = (PWM_W > CMD_W) ? PWM_W : CMD_W;

  localparam logic [0:0] ST_CMD  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [1:0]       sclk_s;
  logic [1:0]       cs_s;
  logic [1:0]       mosi_s;
  logic             sclk_prev;
  logic [0:0]       state;
  logic [0:0]       state_nx;
  logic [CNT_W-1:0] bit_cnt;
  logic [RX_W-2:0]  rx;
  logic [RX_W-1:0]  rx_next;
  logic [PWM_W-1:0] tx;
  logic             wr_cmd;
  logic             load;
  logic             sel;
  logic             rise;
  logic             fall;
  logic             cmd_done;
  logic             word_done;

  // Edge detection and frame-position decode on the synchronised pins
  always_comb begin
    sel       = ~cs_s[1];
    rise      = sel & sclk_s[1] & ~sclk_prev;
    fall      = sel & ~sclk_s[1] & sclk_prev;
    rx_next   = {rx, mosi_s[1]};
    cmd_done  = rise && (state == ST_CMD)  && (bit_cnt == CNT_W'(CMD_W - 1));
    word_done = rise && (state == ST_DATA) && (bit_cnt == CNT_W'(PWM_W - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_CMD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!sel)          state_nx = ST_CMD;
    else if (cmd_done) state_nx = ST_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s    <= 2'b00;
      cs_s      <= 2'b11;
      mosi_s    <= 2'b00;
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      wr_cmd    <= 1'b0;
      load      <= 1'b0;
      miso      <= 1'b0;
      addr      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      sclk_s    <= {sclk_s[0], sclk};
      cs_s      <= {cs_s[0], cs};
      mosi_s    <= {mosi_s[0], mosi};
      sclk_prev <= sclk_s[1];
      wr_en     <= 1'b0;
      if (!sel) begin
        // Deselect aborts whatever partial command or word was in flight
        bit_cnt <= '0;
        rx      <= '0;
        tx      <= '0;
        wr_cmd  <= 1'b0;
        load    <= 1'b0;
        miso    <= 1'b0;
        addr    <= '0;
      end else begin
        if (rise) begin
          rx <= rx_next[RX_W-2:0];
          if (cmd_done) begin
            bit_cnt <= '0;
            wr_cmd  <= rx_next[CMD_WR_BIT];
            addr    <= rx_next[ADDR_W-1:0];
            load    <= 1'b1;
          end else if (word_done) begin
            bit_cnt <= '0;
            wr_en   <= wr_cmd;
            wr_addr <= addr;
            wr_data <= rx_next[PWM_W-1:0];
            addr    <= addr + ADDR_W'(1);
            load    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        // A pending load presents the MSB of the current register
        if (fall) begin
          if (load) begin
            miso <= rd_data[PWM_W-1];
            tx   <= {rd_data[PWM_W-2:0], 1'b0};
            load <= 1'b0;
          end else begin
            miso <= tx[PWM_W-1];
            tx   <= {tx[PWM_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_pwm_driver_param.sv
// Multi-channel PWM generator whose duty, period, enable and polarity
// registers are programmed over SPI; duty/period apply at period boundaries.
module spi_pwm_driver_param
  import spi_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PWM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [PWM_W-1:0] TOP_RST = PWM_W'(reset_top(PWM_W));

  logic [ADDR_W-1:0] spi_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PWM_W-1:0]  wr_data;
  logic [PWM_W-1:0]  rd_data;

  logic [PWM_W-1:0]  cnt;
  logic [PWM_W-1:0]  top_reg;
  logic [PWM_W-1:0]  top_act;
  logic [PWM_W-1:0]  duty_sh  [NUM_CH];
  logic [PWM_W-1:0]  duty_act [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] inv;
  logic [NUM_CH-1:0] raw;
  logic              wrap;

  spi_pwm_spi_slave #(
    .PWM_W (PWM_W)
  ) u_spi (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .rd_data (rd_data),
    .miso    (miso),
    .addr    (spi_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Read mux; duty addresses return the shadow copy
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (spi_addr == ADDR_W'(i)) rd_data = duty_sh[i];
    end
    if (spi_addr == ADDR_PERIOD) rd_data = top_reg;
    if (spi_addr == ADDR_EN)     rd_data = PWM_W'(en);
    if (spi_addr == ADDR_INV)    rd_data = PWM_W'(inv);
  end

  // A newly written TOP below the running count forces an early boundary
  always_comb begin
    wrap = (cnt >= top_act) || (cnt > top_reg);
    raw  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = en[i] & (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      top_reg <= TOP_RST;
      top_act <= TOP_RST;
      en      <= '1;
      inv     <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wrap) begin
        cnt     <= '0;
        top_act <= top_reg;
      end else begin
        cnt <= cnt + PWM_W'(1);
      end
      // Active duty takes the pre-write shadow on a boundary-clock write
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap) duty_act[i] <= duty_sh[i];
        if (wr_en && (wr_addr == ADDR_W'(i))) duty_sh[i] <= wr_data;
      end
      if (wr_en && (wr_addr == ADDR_PERIOD)) top_reg <= wr_data;
      if (wr_en && (wr_addr == ADDR_EN))     en      <= NUM_CH'(wr_data);
      if (wr_en && (wr_addr == ADDR_INV))    inv     <= NUM_CH'(wr_data);
      pwm_out <= raw ^ inv;
    end
  end

endmodule

// File: tb/tb_spi_pwm_driver_param.sv
// Directed bench for spi_pwm_driver_param: SPI frames drive the registers,
// expected readback and PWM measurements flow through a scoreboard queue.
module tb_spi_pwm_driver_param;

  localparam int NUM_CH = 4;
  localparam int PWM_W  = 8;
  localparam int HALF   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [NUM_CH-1:0] pwm_out;

  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  spi_pwm_driver_param #(
    .NUM_CH (NUM_CH),
    .PWM_W  (PWM_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: observed still running, required finished");
    $fatal(1, "timeout");
  end

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, required a queued expectation", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic spi_bits(input logic [15:0] val, input int n, output logic [15:0] rx);
    rx = '0;
    for (int b = n - 1; b >= 0; b--) begin
      mosi = val[b];
      repeat (HALF) @(negedge clk);
      rx[b] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input int n,
                           input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [15:0] rx;
    logic [7:0]  w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    spi_begin();
    spi_bits(16'(cmd), 8, rx);
    for (int k = 0; k < n; k++) spi_bits(16'(w[k]), 8, rx);
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n, input string tag);
    logic [15:0] rx;
    spi_begin();
    spi_bits(16'(cmd), 8, rx);
    for (int k = 0; k < n; k++) begin
      spi_bits(16'h0000, 8, rx);
      check(tag, 32'(rx[7:0]));
    end
    spi_end();
  endtask

  task automatic measure(input int ch, input int n, output int hi, output int rises);
    logic prev;
    logic cur;
    hi = 0;
    rises = 0;
    @(negedge clk);
    prev = pwm_out[ch];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cur = pwm_out[ch];
      if (cur) hi++;
      if (cur && !prev) rises++;
      prev = cur;
    end
  endtask

  task automatic check_pwm(input string tag, input int ch, input int n,
                           input int exp_hi, input int exp_rises);
    int hi;
    int rises;
    expect_val(32'(exp_hi));
    expect_val(32'(exp_rises));
    measure(ch, n, hi, rises);
    check({tag, "_high"}, 32'(hi));
    check({tag, "_rises"}, 32'(rises));
  endtask

  initial begin
    logic [15:0] rx;
    reset = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    expect_val(32'h0); check("reset_pwm", 32'(pwm_out));
    expect_val(32'h0); check("reset_miso", 32'(miso));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    expect_val(32'h0); check("idle_pwm", 32'(pwm_out));

    // Reset register values: TOP, enable, invert
    expect_val(32'hFE); expect_val(32'h0F); expect_val(32'h00);
    spi_read(8'h40, 3, "reset_regs");

    // duty[0]=0x40 at default period 255
    spi_write(8'h80, 1, 8'h40, 8'h00, 8'h00);
    repeat (300) @(negedge clk);
    check_pwm("duty64_ch0", 0, 510, 128, 2);
    check_pwm("duty0_ch1", 1, 50, 0, 0);

    // Shrink TOP to 9 while the counter may be far above it
    spi_write(8'hC0, 1, 8'h09, 8'h00, 8'h00);
    spi_write(8'h81, 1, 8'h05, 8'h00, 8'h00);
    repeat (30) @(negedge clk);
    check_pwm("top9_duty5_ch1", 1, 100, 50, 10);
    spi_write(8'h81, 1, 8'h0C, 8'h00, 8'h00);
    repeat (30) @(negedge clk);
    check_pwm("duty_over_top_ch1", 1, 50, 50, 0);

    // Burst write/read with auto-increment and 7-bit address wrap
    spi_write(8'h80, 3, 8'h10, 8'h20, 8'h30);
    expect_val(32'h10); expect_val(32'h20); expect_val(32'h30);
    spi_read(8'h00, 3, "burst_read");
    expect_val(32'h00); expect_val(32'h10);
    spi_read(8'h7F, 2, "addr_wrap_read");

    // Aborted write after four data bits
    spi_begin();
    spi_bits(16'h0081, 8, rx);
    spi_bits(16'h000F, 4, rx);
    spi_end();
    expect_val(32'h0); check("abort_miso", 32'(miso));
    expect_val(32'h20);
    spi_read(8'h01, 1, "abort_duty1");

    // Disable ch0 with inverted polarity
    spi_write(8'hC1, 2, 8'h0E, 8'h01, 8'h00);
    check_pwm("disabled_inv_ch0", 0, 20, 20, 0);
    check_pwm("enabled_duty0_ch3", 3, 20, 0, 0);
    expect_val(32'h0E); expect_val(32'h01);
    spi_read(8'h41, 2, "en_inv_read");
    expect_val(32'h00);
    spi_read(8'h55, 1, "unmapped_read");

    // Restore, then reset mid-period and mid-frame
    spi_write(8'hC1, 2, 8'h0F, 8'h00, 8'h00);
    spi_write(8'hC0, 1, 8'hFE, 8'h00, 8'h00);
    spi_write(8'h80, 1, 8'h80, 8'h00, 8'h00);
    spi_write(8'h83, 1, 8'hFF, 8'h00, 8'h00);
    repeat (300) @(negedge clk);
    spi_begin();
    spi_bits(16'h0080, 8, rx);
    spi_bits(16'h000F, 4, rx);
    @(negedge clk);
    expect_val(32'h1); check("pre_reset_ch3", 32'(pwm_out[3]));
    #3 reset = 1'b1;
    #1;
    expect_val(32'h0); check("async_reset_pwm", 32'(pwm_out));
    expect_val(32'h0); check("async_reset_miso", 32'(miso));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    spi_end();
    expect_val(32'hFE);
    spi_read(8'h40, 1, "post_reset_top");
    expect_val(32'h00); expect_val(32'h00);
    spi_read(8'h00, 2, "post_reset_duty");
    check_pwm("post_reset_ch0", 0, 20, 0, 0);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
